// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 128x32 SPI driver and its upstream streamer.
// The ROMs hold the panel bring-up command list and the window-reset command list.
package oled_pkg;

  typedef enum logic [2:0] {
    S_RES_LOW,
    S_RES_WAIT,
    S_INIT,
    S_IDLE,
    S_DATA,
    S_SYNC
  } e_state;

  localparam int PANEL_W     = 128;
  localparam int PANEL_H     = 32;
  localparam int PANEL_PAGES = PANEL_H / 8;

  localparam int INIT_LEN = 25;
  localparam int SYNC_LEN = 6;

  // 20 01 selects vertical addressing to match the streamer's y-inner byte order
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h01, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  localparam logic [7:0] SYNC_ROM [SYNC_LEN] = '{
    8'h21, 8'h00, 8'(PANEL_W - 1), 8'h22, 8'h00, 8'(PANEL_PAGES - 1)
  };

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/oled_spi_byte_tx.sv
// SPI mode-0 byte shifter: one start loads a byte, frame is 16 SCLK half-periods
// plus a CS#-high gap, each CLK_DIV cycles long. done_out marks the last gap cycle.
module oled_spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       start_in,
  input  logic [7:0] byte_in,
  input  logic       dc_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       spi_sclk_out,
  output logic       spi_mosi_out,
  output logic       spi_cs_n_out,
  output logic       oled_dc_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] HALF_FIRST = 5'd16;

  logic             r_busy;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_half;
  logic [6:0]       r_shift;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs_n;
  logic             r_dc;

  logic       w_div_tc;
  logic       w_half_tc;
  logic [4:0] w_half_nxt;

  // r_half counts remaining half-periods: odd = SCLK high, even non-zero = SCLK low, 0 = gap
  assign w_div_tc   = (r_div == '0);
  assign w_half_tc  = (r_half == '0);
  assign w_half_nxt = r_half - 5'd1;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_busy  <= 1'b0;
      r_div   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
    end else if (!r_busy) begin
      if (start_in) begin
        r_busy  <= 1'b1;
        r_div   <= DIV_LAST;
        r_half  <= HALF_FIRST;
        r_shift <= byte_in[6:0];
        r_mosi  <= byte_in[7];
        r_sclk  <= 1'b0;
        r_cs_n  <= 1'b0;
        r_dc    <= dc_in;
      end
    end else if (!w_div_tc) begin
      r_div <= r_div - 1'b1;
    end else if (w_half_tc) begin
      r_busy <= 1'b0;
    end else begin
      r_div  <= DIV_LAST;
      r_half <= w_half_nxt;
      if (w_half_nxt == 5'd0) begin
        r_sclk <= 1'b0;
        r_cs_n <= 1'b1;
        r_mosi <= 1'b0;
      end else if (w_half_nxt[0]) begin
        r_sclk <= 1'b1;
      end else begin
        r_sclk  <= 1'b0;
        r_mosi  <= r_shift[6];
        r_shift <= {r_shift[5:0], 1'b0};
      end
    end
  end

  assign busy_out     = r_busy;
  assign done_out     = r_busy & w_div_tc & w_half_tc;
  assign spi_sclk_out = r_sclk;
  assign spi_mosi_out = r_mosi;
  assign spi_cs_n_out = r_cs_n;
  assign oled_dc_out  = r_dc;

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 sequencer: RES# pulse, init command list, then one data byte per write
// strobe and a column/page window reset per sync strobe.
//
// state      | meaning
// S_RES_LOW  | RES# held low for RES_LOW_CYCLES
// S_RES_WAIT | RES# high, settling for RES_WAIT_CYCLES
// S_INIT     | streaming INIT_ROM as commands
// S_IDLE     | ready, accepting write/sync strobes
// S_DATA     | sending the captured data byte
// S_SYNC     | streaming SYNC_ROM as commands
module oled_spi_driver
  import oled_pkg::*;
#(
  parameter int CLK_DIV         = 2,
  parameter int RES_LOW_CYCLES  = 16,
  parameter int RES_WAIT_CYCLES = 64
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic [7:0] data_in,
  input  logic       write_stb_in,
  input  logic       sync_stb_in,
  output logic       ready_out,
  output logic       spi_sclk_out,
  output logic       spi_mosi_out,
  output logic       spi_cs_n_out,
  output logic       oled_dc_out,
  output logic       oled_res_n_out
);

  localparam int CNT_MAX = max3(RES_LOW_CYCLES, RES_WAIT_CYCLES, 17 * CLK_DIV);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RES_LOW_LAST  = CNT_W'(RES_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RES_WAIT_LAST = CNT_W'(RES_WAIT_CYCLES - 1);
  localparam logic [4:0] INIT_LAST = 5'(INIT_LEN - 1);
  localparam logic [4:0] SYNC_LAST = 5'(SYNC_LEN - 1);

  e_state           r_state;
  e_state           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       r_idx;
  logic [4:0]       w_idx_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;

  logic       w_start;
  logic [7:0] w_byte;
  logic       w_dc;
  logic       w_tx_busy;
  logic       w_tx_done;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_RES_LOW;
      r_cnt   <= RES_LOW_LAST;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Sending states issue a start whenever the shifter is free, so every byte
  // costs one load cycle plus its frame.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_start     = 1'b0;
    w_byte      = 8'h00;
    w_dc        = 1'b0;
    case (r_state)
      S_RES_LOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RES_WAIT;
          w_cnt_nxt   = RES_WAIT_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RES_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_INIT: begin
        w_byte  = INIT_ROM[r_idx];
        w_start = !w_tx_busy;
        if (w_tx_done) begin
          if (r_idx == INIT_LAST) w_state_nxt = S_IDLE;
          else                    w_idx_nxt   = r_idx + 5'd1;
        end
      end
      S_IDLE: begin
        if (write_stb_in) begin
          w_state_nxt = S_DATA;
          w_data_nxt  = data_in;
        end else if (sync_stb_in) begin
          w_state_nxt = S_SYNC;
          w_idx_nxt   = '0;
        end
      end
      S_DATA: begin
        w_byte  = r_data;
        w_dc    = 1'b1;
        w_start = !w_tx_busy;
        if (w_tx_done) w_state_nxt = S_IDLE;
      end
      S_SYNC: begin
        w_byte  = SYNC_ROM[r_idx[2:0]];
        w_start = !w_tx_busy;
        if (w_tx_done) begin
          if (r_idx == SYNC_LAST) w_state_nxt = S_IDLE;
          else                    w_idx_nxt   = r_idx + 5'd1;
        end
      end
      default: w_state_nxt = S_RES_LOW;
    endcase
  end

  oled_spi_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte_tx (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .start_in     (w_start),
    .byte_in      (w_byte),
    .dc_in        (w_dc),
    .busy_out     (w_tx_busy),
    .done_out     (w_tx_done),
    .spi_sclk_out (spi_sclk_out),
    .spi_mosi_out (spi_mosi_out),
    .spi_cs_n_out (spi_cs_n_out),
    .oled_dc_out  (oled_dc_out)
  );

  assign ready_out      = (r_state == S_IDLE);
  assign oled_res_n_out = (r_state != S_RES_LOW);

endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: SPI frames are decoded off the pins and matched
// against an expected {dc, byte} queue built from the command lists and accepted strobes.
module tb_oled_spi_driver;

  localparam int CD    = 2;
  localparam int RLOW  = 16;
  localparam int RWAIT = 64;
  localparam int FRAME = 17 * CD + 1;

  logic       clk_in       = 1'b0;
  logic       reset_n_in   = 1'b0;
  logic [7:0] data_in      = 8'h00;
  logic       write_stb_in = 1'b0;
  logic       sync_stb_in  = 1'b0;
  logic       ready_out;
  logic       spi_sclk_out;
  logic       spi_mosi_out;
  logic       spi_cs_n_out;
  logic       oled_dc_out;
  logic       oled_res_n_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  logic [7:0] init_bytes [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h01, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
  logic [7:0] sync_bytes [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  typedef struct {
    logic       w;
    logic       s;
    logic [7:0] d;
    int         hold;
    bit         poke;
    int         exp_low;
  } vec_t;

  vec_t vecs [7];

  oled_spi_driver #(
    .CLK_DIV         (CD),
    .RES_LOW_CYCLES  (RLOW),
    .RES_WAIT_CYCLES (RWAIT)
  ) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .data_in        (data_in),
    .write_stb_in   (write_stb_in),
    .sync_stb_in    (sync_stb_in),
    .ready_out      (ready_out),
    .spi_sclk_out   (spi_sclk_out),
    .spi_mosi_out   (spi_mosi_out),
    .spi_cs_n_out   (spi_cs_n_out),
    .oled_dc_out    (oled_dc_out),
    .oled_res_n_out (oled_res_n_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Pin-level SPI decoder, sampled on the falling clock edge
  initial begin : monitor
    int         bits;
    int         cs_low;
    int         gap;
    logic [7:0] sh;
    logic       p_sclk, p_cs, p_mosi, f_dc;
    logic [8:0] e;
    bits = 0; cs_low = 0; gap = 1000; sh = 8'h00;
    p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0; f_dc = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!reset_n_in) begin
        bits = 0; cs_low = 0; gap = 1000;
        p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0;
      end else begin
        if (spi_sclk_out && p_sclk) chk("mosi_hold_sclk_high", int'(spi_mosi_out), int'(p_mosi));
        if (spi_cs_n_out) chk("sclk_low_cs_high", int'(spi_sclk_out), 0);
        if (ready_out) chk("mosi_idle_zero", int'(spi_mosi_out), 0);
        if (!spi_cs_n_out && p_cs) begin
          chk("cs_gap_min", int'(gap >= CD), 1);
          f_dc = oled_dc_out;
        end
        if (!spi_cs_n_out && !p_cs) chk("dc_stable", int'(oled_dc_out), int'(f_dc));
        if (!spi_cs_n_out) cs_low++;
        if (spi_sclk_out && !p_sclk && !spi_cs_n_out) begin
          sh = {sh[6:0], spi_mosi_out};
          bits++;
        end
        if (spi_cs_n_out && !p_cs) begin
          chk("frame_bits", bits, 8);
          chk("cs_low_cycles", cs_low, 16 * CD);
          chk("frame_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_dc_byte", int'({f_dc, sh}), int'(e));
          end
          bits = 0;
          cs_low = 0;
        end
        if (spi_cs_n_out) gap++;
        else              gap = 0;
        p_sclk = spi_sclk_out;
        p_cs   = spi_cs_n_out;
        p_mosi = spi_mosi_out;
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, int'(ready_out), 0);
    chk({tag, "_sclk"},  int'(spi_sclk_out), 0);
    chk({tag, "_mosi"},  int'(spi_mosi_out), 0);
    chk({tag, "_cs_n"},  int'(spi_cs_n_out), 1);
    chk({tag, "_dc"},    int'(oled_dc_out), 0);
    chk({tag, "_res_n"}, int'(oled_res_n_out), 0);
  endtask

  task automatic reset_and_init(input string tag);
    int low;
    int tot;
    reset_n_in   = 1'b0;
    write_stb_in = 1'b0;
    sync_stb_in  = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_in);
    chk_reset_outs({tag, "_rst"});
    foreach (init_bytes[i]) exp_q.push_back({1'b0, init_bytes[i]});
    @(posedge clk_in);
    #1 reset_n_in = 1'b1;
    low = 0;
    tot = 0;
    while (!ready_out && tot < 3000) begin
      @(negedge clk_in);
      if (!ready_out) begin
        tot++;
        if (!oled_res_n_out) low++;
      end
    end
    chk({tag, "_res_low_cycles"}, low, RLOW);
    chk({tag, "_ready_latency"}, tot, RLOW + RWAIT + 25 * FRAME);
    chk({tag, "_res_n_high"}, int'(oled_res_n_out), 1);
    chk({tag, "_init_drained"}, exp_q.size(), 0);
  endtask

  task automatic xfer(input logic w, input logic s, input logic [7:0] d, input int hold,
                      input bit poke, input int exp_low, input string nm);
    int t;
    int low;
    t = 0;
    while (!ready_out && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    chk({nm, "_ready_before"}, int'(ready_out), 1);
    data_in      = d;
    write_stb_in = w;
    sync_stb_in  = s;
    if (w) exp_q.push_back({1'b1, d});
    else if (s) foreach (sync_bytes[i]) exp_q.push_back({1'b0, sync_bytes[i]});
    low = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (i == hold - 1) begin
        write_stb_in = 1'b0;
        sync_stb_in  = 1'b0;
        data_in      = 8'($urandom);
      end
      if (poke && i == 10) begin
        write_stb_in = 1'b1;
        sync_stb_in  = 1'b1;
        data_in      = 8'($urandom);
      end
      if (poke && i == 12) begin
        write_stb_in = 1'b0;
        sync_stb_in  = 1'b0;
      end
      if (ready_out) break;
      low++;
    end
    write_stb_in = 1'b0;
    sync_stb_in  = 1'b0;
    chk({nm, "_ready_low"}, low, exp_low);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{w: 1'b1, s: 1'b0, d: 8'hA5, hold: 1, poke: 1'b0, exp_low: FRAME};
    vecs[1] = '{w: 1'b0, s: 1'b1, d: 8'h00, hold: 1, poke: 1'b0, exp_low: 6 * FRAME};
    vecs[2] = '{w: 1'b1, s: 1'b0, d: 8'h3C, hold: 2, poke: 1'b0, exp_low: FRAME};
    vecs[3] = '{w: 1'b1, s: 1'b0, d: 8'h00, hold: 1, poke: 1'b1, exp_low: FRAME};
    vecs[4] = '{w: 1'b1, s: 1'b1, d: 8'h7E, hold: 1, poke: 1'b0, exp_low: FRAME};
    vecs[5] = '{w: 1'b1, s: 1'b0, d: 8'hFF, hold: 2, poke: 1'b0, exp_low: FRAME};
    vecs[6] = '{w: 1'b0, s: 1'b1, d: 8'h00, hold: 2, poke: 1'b1, exp_low: 6 * FRAME};

    reset_and_init("init");

    for (int i = 0; i < 7; i++)
      xfer(vecs[i].w, vecs[i].s, vecs[i].d, vecs[i].hold, vecs[i].poke, vecs[i].exp_low,
           $sformatf("vec%0d", i));

    // One full frame as the streamer would send it: 4 pages x 126 bytes, then a sync
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 6 * 21; c++)
        xfer(1'b1, 1'b0, 8'($urandom), int'($urandom_range(1, 2)), 1'b0, FRAME, "stream_wr");
    xfer(1'b0, 1'b1, 8'h00, 1, 1'b0, 6 * FRAME, "stream_sync");

    // Reset in the middle of a data byte
    data_in      = 8'h5A;
    write_stb_in = 1'b1;
    @(negedge clk_in);
    write_stb_in = 1'b0;
    repeat (9) @(negedge clk_in);
    chk("midbyte_cs_active", int'(spi_cs_n_out), 0);
    #1 reset_n_in = 1'b0;
    #1;
    chk_reset_outs("midbyte");
    exp_q.delete();
    reset_and_init("reinit");
    xfer(1'b1, 1'b0, 8'hC3, 1, 1'b0, FRAME, "post_reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
